// File: rtl/boot_loader_ctrl_pkg.sv
// boot_loader_ctrl_pkg: loader FSM states, header layout, targets and error codes.
// Shared by boot_loader_ctrl (feature macro BOOT_LOADER_CHECKSUM_EN).
package boot_loader_ctrl_pkg;

    localparam int LDR_DATA_WIDTH = 32;

    localparam int HDR_TGT_BIT  = 31;
    localparam int HDR_BASE_LSB = 16;
    localparam int HDR_CNT_LSB  = 0;
    localparam int HDR_CNT_W    = 16;

    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_CHECKSUM = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAY     = 3'd2,
        ST_CSUM    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } ldr_state_t;

    // First byte past a segment of cnt words starting at base.
    function automatic logic [31:0] seg_end(
        input logic [31:0]          base,
        input logic [HDR_CNT_W-1:0] cnt
    );
        return base + {14'd0, cnt, 2'b00};
    endfunction

endpackage

// File: rtl/boot_loader_ctrl_checksum.sv
// boot_checksum: wrapping sum of payload words, compared against the trailing word.
// Only built when BOOT_LOADER_CHECKSUM_EN is defined.
`ifdef BOOT_LOADER_CHECKSUM_EN
module boot_checksum #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  acc,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  match
);

    logic [DATA_WIDTH-1:0] sum;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= '0;
        end else if (acc) begin
            sum <= sum + data;
        end
    end

    assign match = (sum == data);

endmodule
`endif

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: streams segment images into IMEM/DMEM and holds the core until loaded.
// Optional trailing checksum word: define BOOT_LOADER_CHECKSUM_EN.
module boot_loader_ctrl
    import boot_loader_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = LDR_DATA_WIDTH,
    parameter int RELEASE_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] imem_w_addr,
    output logic [DATA_WIDTH-1:0] imem_w_dat,
    output logic                  imem_w_enb,
    output logic [ADDR_WIDTH-1:0] dmem_w_addr,
    output logic [DATA_WIDTH-1:0] dmem_w_dat,
    output logic                  dmem_w_enb,
    output logic                  dmem_init_done,
    output logic                  cpu_rst,
    output logic                  cpu_stall,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int REL_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(1) << ADDR_WIDTH;

    ldr_state_t state;
    ldr_state_t state_nxt;

    logic                  hs;
    logic [ADDR_WIDTH-1:0] hdr_base;
    logic [HDR_CNT_W-1:0]  hdr_cnt;
    logic                  hdr_tgt;
    logic                  hdr_misal;
    logic                  hdr_ovf;

    logic                  start_ok;
    logic                  hdr_take;
    logic                  pay_take;
    logic                  err_load;
    err_code_t             err_nxt;
    logic                  rel_load;

    logic                  tgt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [HDR_CNT_W-1:0]  cnt;
    logic [REL_W-1:0]      rel_cnt;
    err_code_t             err_q;

    logic                  wr_imem;
    logic                  wr_dmem;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_dat;

    assign hs        = s_valid & s_ready;
    assign hdr_base  = s_data[HDR_BASE_LSB +: ADDR_WIDTH];
    assign hdr_cnt   = s_data[HDR_CNT_LSB +: HDR_CNT_W];
    assign hdr_tgt   = s_data[HDR_TGT_BIT];
    assign hdr_misal = |hdr_base[1:0];
    assign hdr_ovf   = seg_end(32'(hdr_base), hdr_cnt) > MEM_BYTES;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic csum_ok;

    boot_checksum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_csum (
        .clk   (clk),
        .rst   (rst),
        .clear (start_ok),
        .acc   (pay_take),
        .data  (s_data),
        .match (csum_ok)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        start_ok       = 1'b0;
        hdr_take       = 1'b0;
        pay_take       = 1'b0;
        err_load       = 1'b0;
        err_nxt        = ERR_NONE;
        s_ready        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        err            = 1'b0;
        cpu_rst        = 1'b1;
        cpu_stall      = 1'b1;
        cpu_run        = 1'b0;
        dmem_init_done = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (hs) begin
                    if (hdr_misal) begin
                        err_load  = 1'b1;
                        err_nxt   = ERR_MISALIGN;
                        state_nxt = ST_ERROR;
                    end else if (hdr_ovf) begin
                        err_load  = 1'b1;
                        err_nxt   = ERR_OVERFLOW;
                        state_nxt = ST_ERROR;
                    end else if (hdr_cnt == '0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        state_nxt = ST_CSUM;
`else
                        state_nxt = ST_RELEASE;
`endif
                    end else begin
                        hdr_take  = 1'b1;
                        state_nxt = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (hs) begin
                    pay_take = 1'b1;
                    if (cnt == HDR_CNT_W'(1)) begin
                        state_nxt = ST_HDR;
                    end
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (hs) begin
                    if (csum_ok) begin
                        state_nxt = ST_RELEASE;
                    end else begin
                        err_load  = 1'b1;
                        err_nxt   = ERR_CHECKSUM;
                        state_nxt = ST_ERROR;
                    end
                end
            end
`endif
            ST_RELEASE: begin
                busy = 1'b1;
                if (rel_cnt == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done           = 1'b1;
                cpu_rst        = 1'b0;
                cpu_stall      = 1'b0;
                cpu_run        = 1'b1;
                dmem_init_done = 1'b1;
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            ST_ERROR: begin
                err = 1'b1;
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        rel_load = (state_nxt == ST_RELEASE) && (state != ST_RELEASE);
    end

    // Write strobes are registered: one pulse the cycle after each payload handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt     <= TGT_IMEM;
            addr    <= '0;
            cnt     <= '0;
            rel_cnt <= '0;
            err_q   <= ERR_NONE;
            wr_imem <= 1'b0;
            wr_dmem <= 1'b0;
            wr_addr <= '0;
            wr_dat  <= '0;
        end else begin
            wr_imem <= pay_take & (tgt == TGT_IMEM);
            wr_dmem <= pay_take & (tgt == TGT_DMEM);
            if (pay_take) begin
                wr_addr <= addr;
                wr_dat  <= s_data;
                addr    <= addr + ADDR_WIDTH'(4);
                cnt     <= cnt - HDR_CNT_W'(1);
            end
            if (hdr_take) begin
                tgt  <= hdr_tgt;
                addr <= hdr_base;
                cnt  <= hdr_cnt;
            end
            if (start_ok) begin
                err_q <= ERR_NONE;
            end else if (err_load) begin
                err_q <= err_nxt;
            end
            if (rel_load) begin
                rel_cnt <= REL_W'(RELEASE_DELAY - 1);
            end else if ((state == ST_RELEASE) && (rel_cnt != '0)) begin
                rel_cnt <= rel_cnt - REL_W'(1);
            end
        end
    end

    assign imem_w_addr = wr_addr;
    assign imem_w_dat  = wr_dat;
    assign imem_w_enb  = wr_imem;
    assign dmem_w_addr = wr_addr;
    assign dmem_w_dat  = wr_dat;
    assign dmem_w_enb  = wr_dmem;
    assign err_code    = err_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb_boot_loader_ctrl: directed image loads, error headers and mid-load reset.
// Define BOOT_LOADER_CHECKSUM_EN for both bench and RTL to cover the checksum build.
module tb_boot_loader_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  imem_w_addr;
    logic [31:0] imem_w_dat;
    logic        imem_w_enb;
    logic [9:0]  dmem_w_addr;
    logic [31:0] dmem_w_dat;
    logic        dmem_w_enb;
    logic        dmem_init_done;
    logic        cpu_rst;
    logic        cpu_stall;
    logic        cpu_run;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;

    bit          lp[$];
    logic [9:0]  la[$];
    logic [31:0] ld[$];

    boot_loader_ctrl #(
        .ADDR_WIDTH    (10),
        .DATA_WIDTH    (32),
        .RELEASE_DELAY (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .imem_w_addr    (imem_w_addr),
        .imem_w_dat     (imem_w_dat),
        .imem_w_enb     (imem_w_enb),
        .dmem_w_addr    (dmem_w_addr),
        .dmem_w_dat     (dmem_w_dat),
        .dmem_w_enb     (dmem_w_enb),
        .dmem_init_done (dmem_init_done),
        .cpu_rst        (cpu_rst),
        .cpu_stall      (cpu_stall),
        .cpu_run        (cpu_run),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .err_code       (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log: port (0 imem, 1 dmem), address, data.
    always @(negedge clk) begin
        if (imem_w_enb === 1'b1) begin
            lp.push_back(1'b0);
            la.push_back(imem_w_addr);
            ld.push_back(imem_w_dat);
        end
        if (dmem_w_enb === 1'b1) begin
            lp.push_back(1'b1);
            la.push_back(dmem_w_addr);
            ld.push_back(dmem_w_dat);
        end
    end

    task automatic clear_log();
        lp.delete();
        la.delete();
        ld.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (s_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout: s_ready=%b want 1 word=%h", s_ready, w);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic end_image(input logic [31:0] sum);
        send(32'h0000_0000);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send(sum);
`else
        if (sum === 32'hx) $display("unused");
`endif
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: done=%b want 1", nm, done);
        end
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        got = {cpu_rst, cpu_stall, cpu_run, dmem_init_done, busy, done,
               err, s_ready, imem_w_enb, dmem_w_enb, err_code};
        total++;
        if (got !== 12'b1100_0000_0000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 110000000000", got);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, cpu_rst} !== 2'b01) begin
            bad++;
            $display("FAIL reset_idle: busy,cpu_rst=%b want 01", {busy, cpu_rst});
        end
    endtask

    task automatic test_imem_load();
        logic [31:0] w[3];
        w[0] = 32'h1111_1111;
        w[1] = 32'h2222_2222;
        w[2] = 32'h3333_3333;
        clear_log();
        pulse_start();
        total++;
        if ({busy, s_ready} !== 2'b11) begin
            bad++;
            $display("FAIL imem_hdr_state: busy,s_ready=%b want 11", {busy, s_ready});
        end
        send(32'h0000_0003);
        send(w[0]);
        total++;
        if ({imem_w_enb, dmem_w_enb, imem_w_addr, imem_w_dat} !==
            {2'b10, 10'h000, w[0]}) begin
            bad++;
            $display("FAIL imem_first_write: en=%b%b addr=%h dat=%h want 10 000 %h",
                     imem_w_enb, dmem_w_enb, imem_w_addr, imem_w_dat, w[0]);
        end
        send(w[1]);
        send(w[2]);
        end_image(32'h6666_6666);
        total++;
        if ({busy, done, cpu_rst} !== 3'b101) begin
            bad++;
            $display("FAIL imem_release0: busy,done,cpu_rst=%b want 101", {busy, done, cpu_rst});
        end
        @(negedge clk);
        total++;
        if ({busy, done, cpu_rst} !== 3'b101) begin
            bad++;
            $display("FAIL imem_release1: busy,done,cpu_rst=%b want 101", {busy, done, cpu_rst});
        end
        @(negedge clk);
        total++;
        if ({done, cpu_rst, cpu_stall, cpu_run, dmem_init_done, busy, err} !== 7'b1001100) begin
            bad++;
            $display("FAIL imem_done_state: got %b want 1001100",
                     {done, cpu_rst, cpu_stall, cpu_run, dmem_init_done, busy, err});
        end
        total++;
        if (la.size() != 3) begin
            bad++;
            $display("FAIL imem_write_count: got %0d want 3", la.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if ({lp[i], la[i], ld[i]} !== {1'b0, 10'(4 * i), w[i]}) begin
                    bad++;
                    $display("FAIL imem_write_%0d: port=%b addr=%h dat=%h want 0 %h %h",
                             i, lp[i], la[i], ld[i], 10'(4 * i), w[i]);
                end
            end
        end
    endtask

    task automatic test_dmem_load();
        clear_log();
        pulse_start();
        total++;
        if ({cpu_rst, cpu_stall, dmem_init_done, done} !== 4'b1100) begin
            bad++;
            $display("FAIL restart_hold: rst,stall,init,done=%b want 1100",
                     {cpu_rst, cpu_stall, dmem_init_done, done});
        end
        send(32'h8008_0002);
        send(32'h0000_000A);
        send(32'h0000_000B);
        end_image(32'h0000_0015);
        wait_done("dmem");
        total++;
        if (la.size() != 2) begin
            bad++;
            $display("FAIL dmem_write_count: got %0d want 2", la.size());
        end else begin
            total++;
            if ({lp[0], la[0], ld[0], lp[1], la[1], ld[1]} !==
                {1'b1, 10'h008, 32'hA, 1'b1, 10'h00C, 32'hB}) begin
                bad++;
                $display("FAIL dmem_writes: %b %h %h / %b %h %h want 1 008 a / 1 00c b",
                         lp[0], la[0], ld[0], lp[1], la[1], ld[1]);
            end
        end
    endtask

    task automatic test_misaligned();
        clear_log();
        pulse_start();
        send(32'h0006_0001);
        total++;
        if ({err, err_code, s_ready, busy, cpu_rst} !== 6'b101001) begin
            bad++;
            $display("FAIL misalign_err: err,code,rdy,busy,rst=%b want 101001",
                     {err, err_code, s_ready, busy, cpu_rst});
        end
        total++;
        if (la.size() != 0) begin
            bad++;
            $display("FAIL misalign_writes: got %0d want 0", la.size());
        end
        pulse_start();
        total++;
        if ({err, err_code, busy} !== 4'b0001) begin
            bad++;
            $display("FAIL misalign_restart: err,code,busy=%b want 0001", {err, err_code, busy});
        end
        send(32'h0000_0001);
        send(32'h0000_0055);
        end_image(32'h0000_0055);
        wait_done("recover");
        total++;
        if ({done, err, la.size() == 1} !== 3'b101) begin
            bad++;
            $display("FAIL recover_state: done,err=%b%b writes=%0d want 10 1",
                     done, err, la.size());
        end
    endtask

    task automatic test_overflow();
        clear_log();
        pulse_start();
        send(32'h03FC_0002);
        repeat (2) @(negedge clk);
        total++;
        if ({err, err_code, cpu_rst, cpu_stall} !== 5'b11011) begin
            bad++;
            $display("FAIL overflow_err: err,code,rst,stall=%b want 11011",
                     {err, err_code, cpu_rst, cpu_stall});
        end
        total++;
        if (la.size() != 0) begin
            bad++;
            $display("FAIL overflow_writes: got %0d want 0", la.size());
        end
    endtask

    task automatic test_boundary_fit();
        clear_log();
        pulse_start();
        send(32'h03F8_0002);
        send(32'hC0DE_0001);
        send(32'hC0DE_0002);
        end_image(32'h81BC_0003);
        wait_done("boundary");
        total++;
        if (la.size() != 2) begin
            bad++;
            $display("FAIL boundary_count: got %0d want 2", la.size());
        end else begin
            total++;
            if ({la[0], la[1], lp[0], lp[1]} !== {10'h3F8, 10'h3FC, 2'b00}) begin
                bad++;
                $display("FAIL boundary_addr: %h %h ports %b%b want 3f8 3fc 00",
                         la[0], la[1], lp[0], lp[1]);
            end
        end
    endtask

    task automatic test_gaps_busy_start();
        logic stray;
        stray = 1'b0;
        clear_log();
        pulse_start();
        send(32'h8020_0002);
        send(32'hAAAA_0001);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stray = stray | imem_w_enb | dmem_w_enb;
        repeat (2) begin
            @(negedge clk);
            stray = stray | imem_w_enb | dmem_w_enb;
        end
        total++;
        if ({stray, busy, s_ready} !== 3'b011) begin
            bad++;
            $display("FAIL gap_state: stray,busy,rdy=%b want 011", {stray, busy, s_ready});
        end
        send(32'hAAAA_0002);
        total++;
        if ({dmem_w_enb, imem_w_enb, dmem_w_addr, dmem_w_dat} !==
            {2'b10, 10'h024, 32'hAAAA_0002}) begin
            bad++;
            $display("FAIL gap_second: en=%b%b addr=%h dat=%h want 10 024 aaaa0002",
                     dmem_w_enb, imem_w_enb, dmem_w_addr, dmem_w_dat);
        end
        end_image(32'h5554_0003);
        wait_done("gaps");
        total++;
        if (la.size() != 2) begin
            bad++;
            $display("FAIL gap_count: got %0d want 2", la.size());
        end
    endtask

    task automatic test_rst_mid();
        clear_log();
        pulse_start();
        send(32'h0010_0004);
        send(32'h0000_0077);
        s_data  = 32'h0000_0078;
        s_valid = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, s_ready, imem_w_enb, dmem_w_enb, cpu_rst, cpu_stall} !== 6'b000011) begin
            bad++;
            $display("FAIL rst_mid_state: busy,rdy,ie,de,rst,stall=%b want 000011",
                     {busy, s_ready, imem_w_enb, dmem_w_enb, cpu_rst, cpu_stall});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        total++;
        if (la.size() != 1 || la[0] !== 10'h010) begin
            bad++;
            $display("FAIL rst_mid_writes: count=%0d want 1 at 010", la.size());
        end
    endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send(32'h0000_0003);
        send(32'd1);
        send(32'd2);
        send(32'd3);
        end_image(32'd6);
        wait_done("csum_ok");
        pulse_start();
        send(32'h0000_0003);
        send(32'd1);
        send(32'd2);
        send(32'd3);
        end_image(32'd7);
        total++;
        if ({err, err_code, cpu_stall, done} !== 5'b11110) begin
            bad++;
            $display("FAIL csum_bad: err,code,stall,done=%b want 11110",
                     {err, err_code, cpu_stall, done});
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        test_reset();
        test_imem_load();
        test_dmem_load();
        test_misaligned();
        test_overflow();
        test_boundary_fit();
        test_gaps_busy_start();
        test_rst_mid();
`ifdef BOOT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
